dual_slot_ctrl_pipe: RTL and testbench

- Parametrised, pipelined successor to the dual-slot control decoder.
- Decodes one two-slot instruction bundle per cycle and registers all control into an EX-stage control register:
  - slot 1: ALU ops;
  - slot 2: load, store, jump and branch.
- Adds the following, none of which the combinational generation has:
  - valid/ready intake;
  - load-use and flag-use interlocks;
  - taken-branch squash of the wrong-path bundle;
  - illegal-encoding reporting;
  - saturating stall and flush counters.
- Sits between instruction fetch and the datapath / register-file write control.

---
 rtl/dual_slot_ctrl_pipe_if.sv | 52 +++++
 rtl/dual_slot_ctrl_pipe.sv | 219 +++++++++++++++++++++
 tb/tb_dual_slot_ctrl_pipe.sv | 211 +++++++++++++++++++++
 3 files changed

// File: rtl/dual_slot_ctrl_pipe_if.sv
// Fetch-side handshake and EX-stage control bundle of the dual-slot decoder.
// The decoder takes the slave view; the fetch/datapath side takes the master view.
interface dual_slot_ctrl_pipe_if #(
    parameter int IR_W  = 32,
    parameter int RA_W  = 3,
    parameter int CNT_W = 8
);
    logic             ir_valid;
    logic [IR_W-1:0]  ir;
    logic             ir_ready;
    logic             n_flag;

    logic             ex_valid;
    logic             regWrite1;
    logic             regWrite2;
    logic             z1Write;
    logic             n1Write;
    logic             c1Write;
    logic             v1Write;
    logic             z2Write;
    logic             n2Write;
    logic             c2Write;
    logic             v2Write;
    logic [1:0]       aluOp;
    logic             aluSrcA;
    logic             aluSrcB;
    logic             memRead;
    logic             memWrite;
    logic             branch;
    logic [1:0]       PcSrc;
    logic [RA_W-1:0]  rd1;
    logic [RA_W-1:0]  rd2;
    logic             illegal_op;
    logic [CNT_W-1:0] stall_cnt;
    logic [CNT_W-1:0] flush_cnt;

    modport slave (
        input  ir_valid, ir, n_flag,
        output ir_ready, ex_valid, regWrite1, regWrite2,
               z1Write, n1Write, c1Write, v1Write, z2Write, n2Write, c2Write, v2Write,
               aluOp, aluSrcA, aluSrcB, memRead, memWrite, branch, PcSrc,
               rd1, rd2, illegal_op, stall_cnt, flush_cnt
    );

    modport master (
        output ir_valid, ir, n_flag,
        input  ir_ready, ex_valid, regWrite1, regWrite2,
               z1Write, n1Write, c1Write, v1Write, z2Write, n2Write, c2Write, v2Write,
               aluOp, aluSrcA, aluSrcB, memRead, memWrite, branch, PcSrc,
               rd1, rd2, illegal_op, stall_cnt, flush_cnt
    );
endinterface

// File: rtl/dual_slot_ctrl_pipe.sv
// Pipelined two-slot control decoder: decodes one bundle per cycle into a registered
// EX control word, with load-use / flag-use interlocks and taken-branch squash.
module dual_slot_ctrl_pipe #(
    parameter int IR_W      = 32,
    parameter int OP_W      = 5,
    parameter int RA_W      = 3,
    parameter int SLOT2_OFS = 16,
    parameter int CNT_W     = 8
) (
    input  logic                 clk,
    input  logic                 reset,
    dual_slot_ctrl_pipe_if.slave bus
);
    localparam int F_OFS  = OP_W;
    localparam int RD_OFS = OP_W + 3;
    localparam int RS_OFS = OP_W + 3 + RA_W;

    localparam logic [OP_W-1:0] OP_NOP    = OP_W'(0);
    localparam logic [OP_W-1:0] OP_RTYPE  = OP_W'(8);
    localparam logic [OP_W-1:0] OP_IMM    = OP_W'(5);
    localparam logic [OP_W-1:0] OP_LOAD   = OP_W'(10);
    localparam logic [OP_W-1:0] OP_STORE  = OP_W'(11);
    localparam logic [OP_W-1:0] OP_JUMP   = OP_W'(30);
    localparam logic [OP_W-1:0] OP_BRANCH = OP_W'(27);

    typedef struct packed {
        logic            vld;
        logic            rw1, rw2;
        logic            z1, n1, c1, v1, z2, n2, c2, v2;
        logic [1:0]      aop;
        logic            sa, sb, mr, mw, br;
        logic [1:0]      pc;
        logic [RA_W-1:0] rd1, rd2;
        logic            ill;
    } ex_t;

    typedef enum logic {RUN, BUBBLE} state_e;

    state_e           state_q, state_d;
    ex_t              ex_q, ex_d, dec;
    logic [CNT_W-1:0] stall_q, stall_d, flush_q, flush_d;

    logic [IR_W-1:0]  ir;
    logic [OP_W-1:0]  op1, op2;
    logic [2:0]       func1;
    logic [RA_W-1:0]  rd1f, rs1f, rd2f, rs2f;
    logic             rd_use1, rs_use1, rd_use2, rs_use2, is_br, ill1, ill2;
    logic             squash, load_use, flag_use, hazard;
    logic             ready, take, stall_evt, flush_evt;
    logic             unused_ir;

    assign ir        = bus.ir;
    assign unused_ir = ^ir;

    assign op1   = ir[0 +: OP_W];
    assign func1 = ir[F_OFS +: 3];
    assign rd1f  = ir[RD_OFS +: RA_W];
    assign rs1f  = ir[RS_OFS +: RA_W];
    assign op2   = ir[SLOT2_OFS +: OP_W];
    assign rd2f  = ir[SLOT2_OFS + RD_OFS +: RA_W];
    assign rs2f  = ir[SLOT2_OFS + RS_OFS +: RA_W];

    // Illegal slots decode as nop and read nothing, so they never cause an interlock.
    always_comb begin
        dec     = '0;
        rd_use1 = 1'b0;
        rs_use1 = 1'b0;
        rd_use2 = 1'b0;
        rs_use2 = 1'b0;
        is_br   = 1'b0;
        ill1    = 1'b0;
        ill2    = 1'b0;

        case (op1)
            OP_RTYPE: begin
                if (func1 inside {3'b100, 3'b011, 3'b010}) begin
                    dec.rw1 = 1'b1;
                    dec.sa  = 1'b1;
                    dec.z1  = 1'b1;
                    dec.n1  = 1'b1;
                    dec.rd1 = rd1f;
                    rd_use1 = 1'b1;
                    rs_use1 = 1'b1;
                    case (func1)
                        3'b100:  begin dec.aop = 2'b00; dec.c1 = 1'b1; dec.v1 = 1'b1; end
                        3'b011:  begin dec.aop = 2'b11; dec.c1 = 1'b1; end
                        default: dec.aop = 2'b10;
                    endcase
                end else begin
                    ill1 = 1'b1;
                end
            end
            OP_IMM: begin
                dec.rw1 = 1'b1;
                dec.sb  = 1'b1;
                {dec.z1, dec.n1, dec.c1, dec.v1} = 4'hF;
                dec.aop = 2'b01;
                dec.rd1 = rd1f;
                rs_use1 = 1'b1;
            end
            OP_NOP:  ;
            default: ill1 = 1'b1;
        endcase

        case (op2)
            OP_LOAD: begin
                dec.rw2 = 1'b1;
                dec.mr  = 1'b1;
                dec.z2  = 1'b1;
                dec.n2  = 1'b1;
                dec.rd2 = rd2f;
                rs_use2 = 1'b1;
            end
            OP_STORE: begin
                dec.mw  = 1'b1;
                dec.rd2 = rd2f;
                rs_use2 = 1'b1;
                rd_use2 = 1'b1;
            end
            OP_JUMP: dec.pc = 2'b10;
            OP_BRANCH: begin
                dec.br = 1'b1;
                dec.pc = bus.n_flag ? 2'b01 : 2'b00;
                is_br  = 1'b1;
            end
            OP_NOP:  ;
            default: ill2 = 1'b1;
        endcase

        // Same-bundle write to one register: the later slot owns the result.
        if (dec.rw1 && dec.rw2 && (dec.rd1 == dec.rd2))
            dec.rw1 = 1'b0;

        dec.ill = ill1 | ill2;
        dec.vld = 1'b1;
    end

    assign squash   = (ex_q.pc != 2'b00);
    assign load_use = ex_q.mr && ((rd_use1 && (rd1f == ex_q.rd2)) ||
                                  (rs_use1 && (rs1f == ex_q.rd2)) ||
                                  (rd_use2 && (rd2f == ex_q.rd2)) ||
                                  (rs_use2 && (rs2f == ex_q.rd2)));
    assign flag_use = is_br && (ex_q.n1 || ex_q.n2);
    assign hazard   = bus.ir_valid && (load_use || flag_use);

    always_comb begin
        state_d   = RUN;
        ready     = 1'b1;
        take      = 1'b0;
        stall_evt = 1'b0;
        flush_evt = 1'b0;

        case (state_q)
            RUN: begin
                if (squash) begin
                    flush_evt = bus.ir_valid;
                end else if (hazard) begin
                    ready     = 1'b0;
                    stall_evt = 1'b1;
                    state_d   = BUBBLE;
                end else begin
                    take = bus.ir_valid;
                end
            end
            // EX holds a bubble here, so no hazard or squash can be pending.
            BUBBLE: begin
                take    = bus.ir_valid;
                state_d = RUN;
            end
            default: state_d = RUN;
        endcase

        if (reset)
            ready = 1'b0;

        ex_d    = take ? dec : '0;
        stall_d = (stall_evt && (stall_q != {CNT_W{1'b1}})) ? stall_q + 1'b1 : stall_q;
        flush_d = (flush_evt && (flush_q != {CNT_W{1'b1}})) ? flush_q + 1'b1 : flush_q;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= RUN;
            ex_q    <= '0;
            stall_q <= '0;
            flush_q <= '0;
        end else begin
            state_q <= state_d;
            ex_q    <= ex_d;
            stall_q <= stall_d;
            flush_q <= flush_d;
        end
    end

    assign bus.ir_ready   = ready;
    assign bus.ex_valid   = ex_q.vld;
    assign bus.regWrite1  = ex_q.rw1;
    assign bus.regWrite2  = ex_q.rw2;
    assign bus.z1Write    = ex_q.z1;
    assign bus.n1Write    = ex_q.n1;
    assign bus.c1Write    = ex_q.c1;
    assign bus.v1Write    = ex_q.v1;
    assign bus.z2Write    = ex_q.z2;
    assign bus.n2Write    = ex_q.n2;
    assign bus.c2Write    = ex_q.c2;
    assign bus.v2Write    = ex_q.v2;
    assign bus.aluOp      = ex_q.aop;
    assign bus.aluSrcA    = ex_q.sa;
    assign bus.aluSrcB    = ex_q.sb;
    assign bus.memRead    = ex_q.mr;
    assign bus.memWrite   = ex_q.mw;
    assign bus.branch     = ex_q.br;
    assign bus.PcSrc      = ex_q.pc;
    assign bus.rd1        = ex_q.rd1;
    assign bus.rd2        = ex_q.rd2;
    assign bus.illegal_op = ex_q.ill;
    assign bus.stall_cnt  = stall_q;
    assign bus.flush_cnt  = flush_q;
endmodule

// File: tb/tb_dual_slot_ctrl_pipe.sv
// Directed bench for dual_slot_ctrl_pipe: the driver queues hand-computed per-cycle
// expectations, the monitor pops one each cycle on the falling edge and compares.
module tb_dual_slot_ctrl_pipe;
    typedef struct packed {
        logic       vld;
        logic       rw1, rw2;
        logic [7:0] fl;   // z1 n1 c1 v1 z2 n2 c2 v2
        logic [1:0] aop;
        logic       sa, sb, mr, mw, br;
        logic [1:0] pc;
        logic [2:0] rd1, rd2;
        logic       ill;
    } ex_t;

    typedef struct {
        string nm;
        logic  rdy;
        ex_t   ex;
        int    st;
        int    fc;
    } exp_t;

    localparam logic [4:0] NOP = 5'b00000, RT = 5'b01000, IMM = 5'b00101;
    localparam logic [4:0] LD = 5'b01010, ST = 5'b01011, JMP = 5'b11110, BR = 5'b11011;

    logic clk = 1'b0;
    logic reset = 1'b1;
    int   checks = 0;
    int   errors = 0;
    exp_t sb_q[$];
    bit   done = 1'b0;

    dual_slot_ctrl_pipe_if #(.IR_W(32), .RA_W(3), .CNT_W(2)) bus ();

    dual_slot_ctrl_pipe #(
        .IR_W(32), .OP_W(5), .RA_W(3), .SLOT2_OFS(16), .CNT_W(2)
    ) dut (
        .clk  (clk),
        .reset(reset),
        .bus  (bus)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] bnd(input logic [4:0] o1, input logic [2:0] f1,
                                        input logic [2:0] d1, input logic [2:0] s1,
                                        input logic [4:0] o2, input logic [2:0] d2,
                                        input logic [2:0] s2);
        return {2'b00, s2, d2, 3'b000, o2, 2'b00, s1, d1, f1, o1};
    endfunction

    function automatic ex_t e_imm(input logic [2:0] d);
        ex_t e = '0;
        e.vld = 1'b1; e.rw1 = 1'b1; e.sb = 1'b1; e.fl[7:4] = 4'hF; e.aop = 2'b01; e.rd1 = d;
        return e;
    endfunction

    function automatic ex_t e_rt100(input logic [2:0] d);
        ex_t e = '0;
        e.vld = 1'b1; e.rw1 = 1'b1; e.sa = 1'b1; e.fl[7:4] = 4'hF; e.aop = 2'b00; e.rd1 = d;
        return e;
    endfunction

    function automatic ex_t e_load(input logic [2:0] d);
        ex_t e = '0;
        e.vld = 1'b1; e.rw2 = 1'b1; e.mr = 1'b1; e.fl[3:2] = 2'b11; e.rd2 = d;
        return e;
    endfunction

    function automatic ex_t e_ctl(input logic b, input logic [1:0] p);
        ex_t e = '0;
        e.vld = 1'b1; e.br = b; e.pc = p;
        return e;
    endfunction

    task automatic step(input string nm, input logic v, input logic [31:0] ins, input logic nf,
                        input logic rs, input logic er, input ex_t ee, input int es, input int ef);
        exp_t it;
        @(posedge clk);
        #1;
        bus.ir_valid = v;
        bus.ir       = ins;
        bus.n_flag   = nf;
        reset        = rs;
        it.nm = nm; it.rdy = er; it.ex = ee; it.st = es; it.fc = ef;
        sb_q.push_back(it);
    endtask

    task automatic do_reset(input string nm);
        step(nm, 1'b0, 32'h0, 1'b0, 1'b1, 1'b0, '0, 0, 0);
    endtask

    always @(negedge clk) begin
        exp_t it;
        ex_t  act;
        if (sb_q.size() > 0) begin
            it  = sb_q.pop_front();
            act = {bus.ex_valid, bus.regWrite1, bus.regWrite2,
                   bus.z1Write, bus.n1Write, bus.c1Write, bus.v1Write,
                   bus.z2Write, bus.n2Write, bus.c2Write, bus.v2Write,
                   bus.aluOp, bus.aluSrcA, bus.aluSrcB, bus.memRead, bus.memWrite,
                   bus.branch, bus.PcSrc, bus.rd1, bus.rd2, bus.illegal_op};
            checks++;
            if (bus.ir_ready !== it.rdy) begin
                errors++;
                $display("FAIL %s ir_ready: got %b want %b", it.nm, bus.ir_ready, it.rdy);
            end
            checks++;
            if (act !== it.ex) begin
                errors++;
                $display("FAIL %s ex: got %h want %h", it.nm, act, it.ex);
            end
            checks++;
            if (int'(bus.stall_cnt) != it.st) begin
                errors++;
                $display("FAIL %s stall_cnt: got %0d want %0d", it.nm, bus.stall_cnt, it.st);
            end
            checks++;
            if (int'(bus.flush_cnt) != it.fc) begin
                errors++;
                $display("FAIL %s flush_cnt: got %0d want %0d", it.nm, bus.flush_cnt, it.fc);
            end
        end
    end

    initial begin
        logic [31:0] ba, bb, bc;
        ex_t         e;
        int          sv[6];
        sv = '{0, 1, 2, 3, 3, 3};
        bus.ir_valid = 1'b0;
        bus.ir       = 32'h0;
        bus.n_flag   = 1'b0;

        // Reset asserted during a load-use stall cycle
        ba = bnd(NOP, 3'd0, 3'd0, 3'd0, LD, 3'd3, 3'd0);
        bb = bnd(IMM, 3'd0, 3'd1, 3'd3, NOP, 3'd0, 3'd0);
        do_reset("t1_rst");
        step("t1_a",    1'b1, ba, 1'b0, 1'b0, 1'b1, '0, 0, 0);
        step("t1_mid",  1'b1, bb, 1'b0, 1'b1, 1'b0, '0, 0, 0);
        step("t1_rel",  1'b1, bb, 1'b0, 1'b0, 1'b1, '0, 0, 0);
        step("t1_ex",   1'b0, 32'h0, 1'b0, 1'b0, 1'b1, e_imm(3'd1), 0, 0);

        // Load-use interlock
        do_reset("t2_rst");
        step("t2_a",    1'b1, ba, 1'b0, 1'b0, 1'b1, '0, 0, 0);
        step("t2_stl",  1'b1, bb, 1'b0, 1'b0, 1'b0, e_load(3'd3), 0, 0);
        step("t2_bub",  1'b1, bb, 1'b0, 1'b0, 1'b1, '0, 1, 0);
        step("t2_b",    1'b0, 32'h0, 1'b0, 1'b0, 1'b1, e_imm(3'd1), 1, 0);
        step("t2_idle", 1'b0, 32'h0, 1'b0, 1'b0, 1'b1, '0, 1, 0);

        // Flag-use stall before a taken branch, then wrong-path squash
        ba = bnd(RT, 3'b100, 3'd1, 3'd2, NOP, 3'd0, 3'd0);
        bb = bnd(NOP, 3'd0, 3'd0, 3'd0, BR, 3'd0, 3'd0);
        bc = bnd(IMM, 3'd0, 3'd4, 3'd0, NOP, 3'd0, 3'd0);
        do_reset("t3_rst");
        step("t3_rt",   1'b1, ba, 1'b1, 1'b0, 1'b1, '0, 0, 0);
        step("t3_stl",  1'b1, bb, 1'b1, 1'b0, 1'b0, e_rt100(3'd1), 0, 0);
        step("t3_bub",  1'b1, bb, 1'b1, 1'b0, 1'b1, '0, 1, 0);
        step("t3_sq",   1'b1, bc, 1'b1, 1'b0, 1'b1, e_ctl(1'b1, 2'b01), 1, 0);
        step("t3_flsh", 1'b0, 32'h0, 1'b0, 1'b0, 1'b1, '0, 1, 1);
        step("t3_idle", 1'b0, 32'h0, 1'b0, 1'b0, 1'b1, '0, 1, 1);

        // Jump squash, then a not-taken branch that squashes nothing
        ba = bnd(NOP, 3'd0, 3'd0, 3'd0, JMP, 3'd0, 3'd0);
        bb = bnd(NOP, 3'd0, 3'd0, 3'd0, LD, 3'd5, 3'd0);
        bc = bnd(NOP, 3'd0, 3'd0, 3'd0, BR, 3'd0, 3'd0);
        do_reset("t4_rst");
        step("t4_jmp",  1'b1, ba, 1'b0, 1'b0, 1'b1, '0, 0, 0);
        step("t4_sq",   1'b1, bb, 1'b0, 1'b0, 1'b1, e_ctl(1'b0, 2'b10), 0, 0);
        step("t4_br",   1'b1, bc, 1'b0, 1'b0, 1'b1, '0, 0, 1);
        step("t4_nt",   1'b1, bnd(IMM, 3'd0, 3'd6, 3'd0, NOP, 3'd0, 3'd0), 1'b0, 1'b0, 1'b1,
             e_ctl(1'b1, 2'b00), 0, 1);
        step("t4_keep", 1'b0, 32'h0, 1'b0, 1'b0, 1'b1, e_imm(3'd6), 0, 1);

        // Same-bundle WAW and illegal encodings
        ba = bnd(IMM, 3'd0, 3'd2, 3'd0, LD, 3'd2, 3'd0);
        bb = bnd(RT, 3'b111, 3'd1, 3'd1, ST, 3'd4, 3'd5);
        bc = bnd(IMM, 3'd0, 3'd7, 3'd0, 5'b11111, 3'd0, 3'd0);
        do_reset("t5_rst");
        step("t5_waw",  1'b1, ba, 1'b0, 1'b0, 1'b1, '0, 0, 0);
        e = e_imm(3'd2) | e_load(3'd2);
        e.rw1 = 1'b0;
        step("t5_ill1", 1'b1, bb, 1'b0, 1'b0, 1'b1, e, 0, 0);
        e = '0; e.vld = 1'b1; e.mw = 1'b1; e.rd2 = 3'd4; e.ill = 1'b1;
        step("t5_ill2", 1'b1, bc, 1'b0, 1'b0, 1'b1, e, 0, 0);
        e = e_imm(3'd7); e.ill = 1'b1;
        step("t5_ex2",  1'b0, 32'h0, 1'b0, 1'b0, 1'b1, e, 0, 0);
        step("t5_idle", 1'b0, 32'h0, 1'b0, 1'b0, 1'b1, '0, 0, 0);

        // Stall counter saturation at 3 with a 2-bit counter
        ba = bnd(NOP, 3'd0, 3'd0, 3'd0, LD, 3'd3, 3'd0);
        bb = bnd(IMM, 3'd0, 3'd1, 3'd3, NOP, 3'd0, 3'd0);
        do_reset("t6_rst");
        for (int i = 0; i < 5; i++) begin
            step("t6_a",   1'b1, ba, 1'b0, 1'b0, 1'b1, (i == 0) ? ex_t'('0) : e_imm(3'd1), sv[i], 0);
            step("t6_stl", 1'b1, bb, 1'b0, 1'b0, 1'b0, e_load(3'd3), sv[i], 0);
            step("t6_bub", 1'b1, bb, 1'b0, 1'b0, 1'b1, '0, sv[i+1], 0);
        end
        step("t6_end",  1'b0, 32'h0, 1'b0, 1'b0, 1'b1, e_imm(3'd1), 3, 0);

        repeat (3) @(posedge clk);
        if (sb_q.size() != 0) begin
            errors++;
            $display("FAIL drain: got %0d pending want 0", sb_q.size());
        end
        done = 1'b1;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
